// File: rtl/simple_bus_responder.sv
// Responder end of the addr/data/req bus: detects req rising edges, writes
// in-window transactions into a small register bank, queues them in an event
// FIFO for a valid/ready consumer and counts drops and decode misses.
module simple_bus_responder #(
  parameter int unsigned          ADDR_W     = 8,
  parameter int unsigned          DATA_W     = 8,
  parameter int unsigned          NUM_REGS   = 4,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = 'h10,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [ADDR_W-1:0]             bus_addr_i,
  input  logic [DATA_W-1:0]             bus_data_i,
  input  logic                          bus_req_i,
  input  logic [$clog2(NUM_REGS)-1:0]   rd_sel_i,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [ADDR_W-1:0]             evt_addr_o,
  output logic [DATA_W-1:0]             evt_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [7:0]                    drop_cnt_o,
  output logic [7:0]                    addr_err_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] TOP_EXT  = BASE_EXT + (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic                req_q;
  logic                rise;
  logic                hit;
  logic [ADDR_W:0]     addr_ext;
  logic [IDX_W-1:0]    reg_idx;

  logic [DATA_W-1:0]   regs     [NUM_REGS];
  logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic                push_req;
  logic                push_ok;
  logic                drop;
  logic                pop;
  logic                valid;
  logic                miss;

  // Edge detect, window decode and FIFO accept/drop decision
  always_comb begin
    addr_ext = {1'b0, bus_addr_i};
    rise     = bus_req_i & ~req_q;
    hit      = (addr_ext >= BASE_EXT) && (addr_ext <= TOP_EXT);
    // Window is NUM_REGS-aligned, so the low address bits are the bank index.
    reg_idx  = bus_addr_i[IDX_W-1:0];
    valid    = (count != '0);
    pop      = valid & evt_ready_i;
    push_req = rise & hit;
    push_ok  = push_req & ((count < DEPTH_C) | pop);
    drop     = push_req & ~push_ok;
    miss     = rise & ~hit;
  end

  // Request history; starts high so a req already asserted at reset release is ignored
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) req_q <= 1'b1;
    else           req_q <= bus_req_i;
  end

  // Register bank write on every in-window transaction, even when the FIFO drops it
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (push_req) begin
      regs[reg_idx] <= bus_data_i;
    end
  end

  // Event FIFO storage and pointers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem_addr[wr_ptr] <= bus_addr_i;
        mem_data[wr_ptr] <= bus_data_i;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracked separately from the pointers so full/empty never alias
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) count <= '0;
    else begin
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating drop and decode-miss counters
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drop_cnt_o     <= '0;
      addr_err_cnt_o <= '0;
    end else begin
      if (drop && (drop_cnt_o != '1))     drop_cnt_o     <= drop_cnt_o + 1'b1;
      if (miss && (addr_err_cnt_o != '1)) addr_err_cnt_o <= addr_err_cnt_o + 1'b1;
    end
  end

  // Output views; FIFO head forced to zero when nothing is queued
  always_comb begin
    rd_data_o    = regs[rd_sel_i];
    evt_valid_o  = valid;
    evt_addr_o   = valid ? mem_addr[rd_ptr] : '0;
    evt_data_o   = valid ? mem_data[rd_ptr] : '0;
    fifo_count_o = count;
  end

endmodule

// File: tb/tb_simple_bus_responder.sv
// Directed self-checking bench for simple_bus_responder.
module tb_simple_bus_responder;

  logic       clk_i;
  logic       reset_ni;
  logic [7:0] bus_addr_i;
  logic [7:0] bus_data_i;
  logic       bus_req_i;
  logic [1:0] rd_sel_i;
  logic [7:0] rd_data_o;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [7:0] evt_addr_o;
  logic [7:0] evt_data_o;
  logic [2:0] fifo_count_o;
  logic [7:0] drop_cnt_o;
  logic [7:0] addr_err_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  simple_bus_responder #(
    .ADDR_W(8), .DATA_W(8), .NUM_REGS(4), .BASE_ADDR(8'h10), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_req_i(bus_req_i),
    .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_addr_o(evt_addr_o), .evt_data_o(evt_data_o),
    .fifo_count_o(fifo_count_o), .drop_cnt_o(drop_cnt_o),
    .addr_err_cnt_o(addr_err_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; everything happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic [7:0] a, input logic [7:0] d);
    bus_addr_i = a;
    bus_data_i = d;
    bus_req_i  = 1'b1;
    tick();
    bus_req_i  = 1'b0;
    tick();
  endtask

  task automatic check_reg(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    rd_sel_i = sel;
    #1;
    check(tag, rd_data_o, exp);
  endtask

  logic [7:0] exp_addr [4];
  logic [7:0] exp_data [4];

  initial begin
    reset_ni    = 1'b0;
    bus_req_i   = 1'b1;
    bus_addr_i  = 8'h10;
    bus_data_i  = 8'h55;
    rd_sel_i    = 2'd0;
    evt_ready_i = 1'b0;
    tick();
    tick();
    check("reset_valid", evt_valid_o, 0);
    check("reset_count", fifo_count_o, 0);

    // Release with req already high: must not be a transaction
    reset_ni = 1'b1;
    tick();
    tick();
    check_reg(2'd0, 8'h00, "held_req_reg0");
    check("held_req_valid", evt_valid_o, 0);
    check("held_req_drop", drop_cnt_o, 0);
    check("held_req_err", addr_err_cnt_o, 0);

    bus_req_i = 1'b0;
    tick();
    bus_req_i = 1'b1;
    tick();
    check_reg(2'd0, 8'h55, "first_reg0");
    check("first_valid", evt_valid_o, 1);
    check("first_addr", evt_addr_o, 8'h10);
    check("first_data", evt_data_o, 8'h55);
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    check("first_pop_count", fifo_count_o, 0);
    check("first_pop_addr", evt_addr_o, 0);
    bus_req_i = 1'b0;
    tick();

    // Long req hold at 0x13: exactly one event
    bus_addr_i  = 8'h13;
    bus_data_i  = 8'hA5;
    bus_req_i   = 1'b1;
    evt_ready_i = 1'b1;
    tick();
    check("hold_count1", fifo_count_o, 1);
    check("hold_head", evt_data_o, 8'hA5);
    for (int i = 0; i < 9; i++) tick();
    check("hold_count_end", fifo_count_o, 0);
    check("hold_valid_end", evt_valid_o, 0);
    check("hold_drop", drop_cnt_o, 0);
    check_reg(2'd3, 8'hA5, "hold_reg3");
    bus_req_i   = 1'b0;
    evt_ready_i = 1'b0;
    tick();

    // Out-of-window addresses below, above and at the top of the space
    pulse(8'h0F, 8'h77);
    pulse(8'h14, 8'h77);
    pulse(8'hFF, 8'h77);
    check("miss_err3", addr_err_cnt_o, 3);
    check("miss_count", fifo_count_o, 0);
    check_reg(2'd0, 8'h55, "miss_reg0");
    check_reg(2'd1, 8'h00, "miss_reg1");
    check_reg(2'd2, 8'h00, "miss_reg2");
    check_reg(2'd3, 8'hA5, "miss_reg3");
    for (int i = 0; i < 300; i++) pulse(8'h20, 8'h00);
    check("miss_err_sat", addr_err_cnt_o, 255);

    // Overfill: six pushes with no consumer
    for (int i = 1; i <= 6; i++) pulse(8'h10 + 8'((i - 1) % 4), 8'(i));
    check("full_count", fifo_count_o, 4);
    check("full_drop", drop_cnt_o, 2);
    check("full_head", evt_data_o, 1);
    check_reg(2'd0, 8'd5, "full_reg0");
    check_reg(2'd1, 8'd6, "full_reg1");
    check_reg(2'd2, 8'd3, "full_reg2");
    check_reg(2'd3, 8'd4, "full_reg3");

    // Push and pop on the same edge while full
    bus_addr_i  = 8'h10;
    bus_data_i  = 8'h07;
    bus_req_i   = 1'b1;
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    bus_req_i   = 1'b0;
    check("pp_count", fifo_count_o, 4);
    check("pp_drop", drop_cnt_o, 2);
    check_reg(2'd0, 8'h07, "pp_reg0");
    tick();

    // Drain across pointer wrap
    exp_addr[0] = 8'h11; exp_data[0] = 8'd2;
    exp_addr[1] = 8'h12; exp_data[1] = 8'd3;
    exp_addr[2] = 8'h13; exp_data[2] = 8'd4;
    exp_addr[3] = 8'h10; exp_data[3] = 8'd7;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), evt_valid_o, 1);
      check($sformatf("drain_addr%0d", i), evt_addr_o, exp_addr[i]);
      check($sformatf("drain_data%0d", i), evt_data_o, exp_data[i]);
      evt_ready_i = 1'b1;
      tick();
      evt_ready_i = 1'b0;
    end
    check("drain_count", fifo_count_o, 0);
    check("drain_data_zero", evt_data_o, 0);

    // Async reset mid-cycle with three entries queued
    pulse(8'h10, 8'd8);
    pulse(8'h11, 8'd9);
    pulse(8'h12, 8'd10);
    check("pre_rst_count", fifo_count_o, 3);
    bus_addr_i = 8'h13;
    bus_data_i = 8'hEE;
    bus_req_i  = 1'b1;
    rd_sel_i   = 2'd0;
    #3;
    reset_ni = 1'b0;
    #1;
    check("rst_count", fifo_count_o, 0);
    check("rst_valid", evt_valid_o, 0);
    check("rst_data", evt_data_o, 0);
    check("rst_reg0", rd_data_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_err", addr_err_cnt_o, 0);
    #2;
    reset_ni = 1'b1;
    tick();
    tick();
    check("post_rst_valid", evt_valid_o, 0);
    check("post_rst_count", fifo_count_o, 0);
    check_reg(2'd3, 8'h00, "post_rst_reg3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
